// File: rtl/poly_tone_gen.sv
// ---------------------------------------------------------------------------
// poly_tone_gen
//
// Polyphonic square-wave tone generator. Each of NUM_VOICES voices holds a
// note/octave setting and produces a square wave whose period is taken from a
// divider table selected by CLK_HZ, right-shifted by the octave. New settings
// are staged in a per-voice pending register and only take effect at a period
// boundary, or immediately if the voice is idle, so the waveform never glitches.
//
// Optional feature: define POLY_TONE_DUTY_EN to add a per-voice duty selector
// (duty_i) that is captured and applied together with the note.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   load_i     per-voice one-cycle load strobe
//   note_i     note code, voice v in [4v+3:4v]; 1..13 = C..C', others = off
//   octave_i   octave, voice v in [3v+2:3v]; divider is shifted right by it
//   duty_i     (POLY_TONE_DUTY_EN only) duty code, voice v in [2v+1:2v]
//   wave_o     registered square wave per voice
//   wrap_o     one-cycle pulse after each period boundary of an active voice
//   pending_o  high while a loaded setting awaits application
//   mix_o      registered count of wave_o bits that are high
// ---------------------------------------------------------------------------
module poly_tone_gen #(
   parameter int NUM_VOICES = 4,
   parameter int CLK_HZ     = 12000000,
   parameter int DIV_W      = 19
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_VOICES-1:0]             load_i,
   input  logic [4*NUM_VOICES-1:0]           note_i,
   input  logic [3*NUM_VOICES-1:0]           octave_i,
`ifdef POLY_TONE_DUTY_EN
   input  logic [2*NUM_VOICES-1:0]           duty_i,
`endif
   output logic [NUM_VOICES-1:0]             wave_o,
   output logic [NUM_VOICES-1:0]             wrap_o,
   output logic [NUM_VOICES-1:0]             pending_o,
   output logic [$clog2(NUM_VOICES+1)-1:0]   mix_o
);

   localparam int MIX_W = $clog2(NUM_VOICES + 1);

   // Clock cycles per full period at octave 0 for the selected clock.
   function automatic logic [DIV_W-1:0] base_div(input logic [3:0] note);
      logic [DIV_W-1:0] d;
      d = '0;
      if (CLK_HZ == 10000000) begin
         case (note)
            4'd1:    d = DIV_W'(305780);
            4'd2:    d = DIV_W'(288618);
            4'd3:    d = DIV_W'(272419);
            4'd4:    d = DIV_W'(257130);
            4'd5:    d = DIV_W'(242698);
            4'd6:    d = DIV_W'(229077);
            4'd7:    d = DIV_W'(216219);
            4'd8:    d = DIV_W'(204084);
            4'd9:    d = DIV_W'(192630);
            4'd10:   d = DIV_W'(181818);
            4'd11:   d = DIV_W'(171618);
            4'd12:   d = DIV_W'(161982);
            4'd13:   d = DIV_W'(152890);
            default: d = '0;
         endcase
      end else begin
         case (note)
            4'd1:    d = DIV_W'(366937);
            4'd2:    d = DIV_W'(346342);
            4'd3:    d = DIV_W'(326903);
            4'd4:    d = DIV_W'(308556);
            4'd5:    d = DIV_W'(291238);
            4'd6:    d = DIV_W'(274892);
            4'd7:    d = DIV_W'(259463);
            4'd8:    d = DIV_W'(244901);
            4'd9:    d = DIV_W'(231156);
            4'd10:   d = DIV_W'(218182);
            4'd11:   d = DIV_W'(205936);
            4'd12:   d = DIV_W'(194378);
            4'd13:   d = DIV_W'(183468);
            default: d = '0;
         endcase
      end
      return d;
   endfunction

   function automatic logic note_valid(input logic [3:0] note);
      return (note >= 4'd1) && (note <= 4'd13);
   endfunction

   // Active setting and counter per voice
   logic [DIV_W-1:0]      per_q  [NUM_VOICES];
   logic [DIV_W-1:0]      cnt_q  [NUM_VOICES];
   logic [NUM_VOICES-1:0] act_q;

   // Pending setting per voice; vld_q says whether it is waiting
   logic [3:0]            pnote_q [NUM_VOICES];
   logic [2:0]            poct_q  [NUM_VOICES];
   logic [NUM_VOICES-1:0] vld_q;

`ifdef POLY_TONE_DUTY_EN
   logic [1:0]            pduty_q [NUM_VOICES];
   logic [1:0]            duty_q  [NUM_VOICES];
`endif

   logic [NUM_VOICES-1:0] at_end;
   logic [NUM_VOICES-1:0] apply;
   logic [DIV_W-1:0]      thr     [NUM_VOICES];
   logic [DIV_W-1:0]      new_per [NUM_VOICES];
   logic [MIX_W-1:0]      ones;

   // NOTE: every always_comb output gets a default before any conditional
   // logic, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      ones = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         at_end[v]  = act_q[v] && (cnt_q[v] == per_q[v] - DIV_W'(1));
         // An idle voice takes its pending setting at once; a running one
         // waits for the end of its current period.
         apply[v]   = vld_q[v] && (!act_q[v] || at_end[v]);
         new_per[v] = base_div(pnote_q[v]) >> poct_q[v];
`ifdef POLY_TONE_DUTY_EN
         case (duty_q[v])
            2'd0:    thr[v] = per_q[v] >> 1;
            2'd1:    thr[v] = per_q[v] >> 2;
            2'd2:    thr[v] = per_q[v] - (per_q[v] >> 2);
            default: thr[v] = per_q[v] >> 3;
         endcase
`else
         thr[v]     = per_q[v] >> 1;
`endif
         ones = ones + MIX_W'(wave_o[v]);
      end
   end

   // NOTE: the pending payload has no reset; vld_q qualifies it, so its
   // contents after reset are never used and the flops stay reset-free.
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (load_i[v]) begin
            pnote_q[v] <= note_i[4*v +: 4];
            poct_q[v]  <= octave_i[3*v +: 3];
`ifdef POLY_TONE_DUTY_EN
            pduty_q[v] <= duty_i[2*v +: 2];
`endif
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            per_q[v] <= '0;
            cnt_q[v] <= '0;
`ifdef POLY_TONE_DUTY_EN
            duty_q[v] <= '0;
`endif
         end
         act_q  <= '0;
         vld_q  <= '0;
         wave_o <= '0;
         wrap_o <= '0;
         mix_o  <= '0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (apply[v]) begin
               // An off note yields a zero divider and clears the active flag.
               act_q[v] <= note_valid(pnote_q[v]);
               per_q[v] <= new_per[v];
               cnt_q[v] <= '0;
`ifdef POLY_TONE_DUTY_EN
               duty_q[v] <= pduty_q[v];
`endif
            end else if (at_end[v]) begin
               cnt_q[v] <= '0;
            end else if (act_q[v]) begin
               cnt_q[v] <= cnt_q[v] + DIV_W'(1);
            end

            // A load in the apply cycle re-arms pending with the new value;
            // the value being applied is the one captured earlier.
            if (load_i[v]) begin
               vld_q[v] <= 1'b1;
            end else if (apply[v]) begin
               vld_q[v] <= 1'b0;
            end

            wave_o[v] <= act_q[v] && (cnt_q[v] < thr[v]);
            wrap_o[v] <= at_end[v];
         end
         mix_o <= ones;
      end
   end

   assign pending_o = vld_q;

endmodule
